// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types: response status encoding, bus arbiter FSM states
// and a helper for index widths.
package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      RggenOkay   = 2'b00,
      RggenExokay = 2'b01,
      RggenSlverr = 2'b10,
      RggenDecerr = 2'b11
   } rggen_status_e;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StRespond
   } rggen_bus_arbiter_state_e;

   // A single requester still gets a 1-bit index so the ports never collapse.
   function automatic int unsigned rggen_index_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// Combinational round-robin arbiter: first request at index >= pointer wins,
// otherwise the search wraps to index 0.
module rggen_round_robin_arbiter
   import rggen_rtl_pkg::*;
#(
   parameter int unsigned HOSTS       = 2,
   parameter int unsigned INDEX_WIDTH = rggen_index_width(HOSTS)
) (
   input  logic [HOSTS-1:0]       i_request,
   input  logic [INDEX_WIDTH-1:0] i_pointer,
   output logic [HOSTS-1:0]       o_grant,
   output logic [INDEX_WIDTH-1:0] o_grant_index
);

   logic found;

   always_comb begin
      o_grant       = '0;
      o_grant_index = '0;
      found         = 1'b0;
      for (int i = 0; i < HOSTS; i++) begin
         if (!found && i_request[i] && (i >= int'(i_pointer))) begin
            found         = 1'b1;
            o_grant[i]    = 1'b1;
            o_grant_index = INDEX_WIDTH'(i);
         end
      end
      for (int i = 0; i < HOSTS; i++) begin
         if (!found && i_request[i]) begin
            found         = 1'b1;
            o_grant[i]    = 1'b1;
            o_grant_index = INDEX_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin sharing of one downstream register-bus port among HOSTS masters.
// Optional downstream timeout: define RGGEN_BUS_ARBITER_TIMEOUT_EN.
module rggen_bus_arbiter
   import rggen_rtl_pkg::*;
#(
   parameter int unsigned HOSTS         = 2,
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned BUS_WIDTH     = 32,
   parameter int unsigned TIMEOUT       = 255
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic [HOSTS-1:0]                     i_valid,
   input  logic [HOSTS-1:0][ADDRESS_WIDTH-1:0]  i_address,
   input  logic [HOSTS-1:0]                     i_write,
   input  logic [HOSTS-1:0][BUS_WIDTH-1:0]      i_write_data,
   input  logic [HOSTS-1:0][BUS_WIDTH/8-1:0]    i_strobe,
   output logic [HOSTS-1:0]                     o_ready,
   output logic [1:0]                           o_status,
   output logic [BUS_WIDTH-1:0]                 o_read_data,
   output logic                                 o_bus_valid,
   output logic [ADDRESS_WIDTH-1:0]             o_bus_address,
   output logic                                 o_bus_write,
   output logic [BUS_WIDTH-1:0]                 o_bus_write_data,
   output logic [BUS_WIDTH/8-1:0]               o_bus_strobe,
   input  logic                                 i_bus_ready,
   input  logic [1:0]                           i_bus_status,
   input  logic [BUS_WIDTH-1:0]                 i_bus_read_data
);

   localparam int unsigned IndexWidth  = rggen_index_width(HOSTS);
   localparam int unsigned StrobeWidth = BUS_WIDTH / 8;

   if ((HOSTS < 1) || (TIMEOUT < 1)) begin : g_param_check
      $error("rggen_bus_arbiter: HOSTS and TIMEOUT must be at least 1");
   end

   rggen_bus_arbiter_state_e state_q, state_d;
   logic [IndexWidth-1:0]    ptr_q, ptr_d;
   logic [IndexWidth-1:0]    grant_q, grant_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic                     write_q, write_d;
   logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
   logic [StrobeWidth-1:0]   strobe_q, strobe_d;
   logic [1:0]               status_q, status_d;
   logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;

   logic [HOSTS-1:0]         rr_grant;
   logic [IndexWidth-1:0]    rr_index;
   logic [ADDRESS_WIDTH-1:0] sel_addr;
   logic                     sel_write;
   logic [BUS_WIDTH-1:0]     sel_wdata;
   logic [StrobeWidth-1:0]   sel_strobe;
   logic                     timeout;

   rggen_round_robin_arbiter #(
      .HOSTS       (HOSTS),
      .INDEX_WIDTH (IndexWidth)
   ) u_rr_arbiter (
      .i_request     (i_valid),
      .i_pointer     (ptr_q),
      .o_grant       (rr_grant),
      .o_grant_index (rr_index)
   );

   // AND-OR mux on the one-hot grant.
   always_comb begin
      sel_addr   = '0;
      sel_write  = 1'b0;
      sel_wdata  = '0;
      sel_strobe = '0;
      for (int i = 0; i < HOSTS; i++) begin
         sel_addr   = sel_addr   | ({ADDRESS_WIDTH{rr_grant[i]}} & i_address[i]);
         sel_write  = sel_write  | (rr_grant[i] & i_write[i]);
         sel_wdata  = sel_wdata  | ({BUS_WIDTH{rr_grant[i]}} & i_write_data[i]);
         sel_strobe = sel_strobe | ({StrobeWidth{rr_grant[i]}} & i_strobe[i]);
      end
   end

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
   localparam int unsigned CountWidth =
      ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CountWidth-1:0] count_q, count_d;

   // Held at zero outside ACCESS, so every access starts counting from zero.
   always_comb begin
      count_d = '0;
      if (state_q == StAccess) begin
         count_d = count_q + CountWidth'(1);
      end
   end

   assign timeout = (state_q == StAccess) && (count_q == CountWidth'(TIMEOUT - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      strobe_d = strobe_q;
      status_d = status_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (|i_valid) begin
               state_d  = StAccess;
               grant_d  = rr_index;
               addr_d   = sel_addr;
               write_d  = sel_write;
               wdata_d  = sel_wdata;
               strobe_d = sel_strobe;
            end
         end
         StAccess: begin
            // A real response beats a simultaneous timeout.
            if (i_bus_ready) begin
               state_d  = StRespond;
               status_d = i_bus_status;
               rdata_d  = i_bus_read_data;
            end else if (timeout) begin
               state_d  = StRespond;
               status_d = RggenSlverr;
               rdata_d  = '0;
            end
         end
         StRespond: begin
            state_d = StIdle;
            ptr_d   = (grant_q == IndexWidth'(HOSTS - 1)) ? '0 : grant_q + IndexWidth'(1);
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         grant_q  <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         strobe_q <= '0;
         status_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         strobe_q <= strobe_d;
         status_q <= status_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      o_ready = '0;
      for (int i = 0; i < HOSTS; i++) begin
         o_ready[i] = (state_q == StRespond) && (grant_q == IndexWidth'(i));
      end
   end

   assign o_status         = status_q;
   assign o_read_data      = rdata_q;
   assign o_bus_valid      = (state_q == StAccess);
   assign o_bus_address    = addr_q;
   assign o_bus_write      = write_q;
   assign o_bus_write_data = wdata_q;
   assign o_bus_strobe     = strobe_q;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Self-checking bench for rggen_bus_arbiter (HOSTS=2, 8-bit address, 32-bit data).
module tb_rggen_bus_arbiter;

   localparam int unsigned Hosts = 2;
   localparam int unsigned Aw    = 8;
   localparam int unsigned Bw    = 32;
   localparam int unsigned Tmo   = 4;
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
   localparam int LongDelay = 4;
`else
   localparam int LongDelay = 5;
`endif

   logic                          clk = 1'b0;
   logic                          rst_n = 1'b1;
   logic [Hosts-1:0]              valid;
   logic [Hosts-1:0][Aw-1:0]      address;
   logic [Hosts-1:0]              write;
   logic [Hosts-1:0][Bw-1:0]      write_data;
   logic [Hosts-1:0][Bw/8-1:0]    strobe;
   logic [Hosts-1:0]              ready;
   logic [1:0]                    status;
   logic [Bw-1:0]                 read_data;
   logic                          bus_valid;
   logic [Aw-1:0]                 bus_address;
   logic                          bus_write;
   logic [Bw-1:0]                 bus_write_data;
   logic [Bw/8-1:0]               bus_strobe;
   logic                          bus_ready;
   logic [1:0]                    bus_status;
   logic [Bw-1:0]                 bus_read_data;

   int checks = 0;
   int errors = 0;

   rggen_bus_arbiter #(
      .HOSTS         (Hosts),
      .ADDRESS_WIDTH (Aw),
      .BUS_WIDTH     (Bw),
      .TIMEOUT       (Tmo)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_valid          (valid),
      .i_address        (address),
      .i_write          (write),
      .i_write_data     (write_data),
      .i_strobe         (strobe),
      .o_ready          (ready),
      .o_status         (status),
      .o_read_data      (read_data),
      .o_bus_valid      (bus_valid),
      .o_bus_address    (bus_address),
      .o_bus_write      (bus_write),
      .o_bus_write_data (bus_write_data),
      .o_bus_strobe     (bus_strobe),
      .i_bus_ready      (bus_ready),
      .i_bus_status     (bus_status),
      .i_bus_read_data  (bus_read_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          host;
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          delay;       // ACCESS cycle carrying bus ready; 0 = never
      logic [1:0]  bstat;
      logic [31:0] brdata;
      int          exp_cycles;
      logic [1:0]  exp_ready;
      logic [1:0]  exp_status;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transaction from IDLE through RESPOND and back to IDLE.
   task automatic run_vec(input string tag, input vec_t v);
      int cycles;
      valid[v.host]      = 1'b1;
      address[v.host]    = v.addr;
      write[v.host]      = v.wr;
      write_data[v.host] = v.wdata;
      strobe[v.host]     = v.strb;
      step();
      chk({tag, " bus_valid"}, 32'(bus_valid), 32'd1);
      chk({tag, " bus_addr"}, 32'(bus_address), 32'(v.addr));
      chk({tag, " bus_write"}, 32'(bus_write), 32'(v.wr));
      chk({tag, " bus_wdata"}, bus_write_data, v.wdata);
      chk({tag, " bus_strobe"}, 32'(bus_strobe), 32'(v.strb));
      address[v.host] = ~v.addr;
      cycles = 0;
      while (bus_valid && cycles < 30) begin
         cycles++;
         if (cycles == v.delay) begin
            bus_ready     = 1'b1;
            bus_status    = v.bstat;
            bus_read_data = v.brdata;
         end
         step();
         bus_ready     = 1'b0;
         bus_status    = 2'b11;
         bus_read_data = 32'hFFFF_FFFF;
      end
      chk({tag, " addr_stable"}, 32'(bus_address), 32'(v.addr));
      chk({tag, " valid_cycles"}, 32'(cycles), 32'(v.exp_cycles));
      chk({tag, " ready"}, 32'(ready), 32'(v.exp_ready));
      chk({tag, " status"}, 32'(status), 32'(v.exp_status));
      chk({tag, " rdata"}, read_data, v.exp_rdata);
      valid[v.host] = 1'b0;
      step();
      chk({tag, " ready_idle"}, 32'(ready), 32'd0);
      chk({tag, " bus_idle"}, 32'(bus_valid), 32'd0);
   endtask

   initial begin
      logic [1:0] exp_seq[4];
      logic [1:0] prev;
      int         n;
      int         last;
      vec_t       tv;

      vecs[0] = '{0, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 1, 2'b00, 32'h0000_0000,
                  1, 2'b01, 2'b00, 32'h0000_0000};
      vecs[1] = '{1, 1'b0, 8'h44, 32'h0000_0000, 4'h0, LongDelay, 2'b10, 32'h1234_5678,
                  LongDelay, 2'b10, 2'b10, 32'h1234_5678};
      vecs[2] = '{0, 1'b0, 8'h20, 32'h0000_0000, 4'h0, 2, 2'b01, 32'hA5A5_A5A5,
                  2, 2'b01, 2'b01, 32'hA5A5_A5A5};
      vecs[3] = '{1, 1'b1, 8'hFF, 32'h0000_0001, 4'h3, 3, 2'b11, 32'h0000_0000,
                  3, 2'b10, 2'b11, 32'h0000_0000};
      vecs[4] = '{0, 1'b1, 8'h00, 32'h8000_0000, 4'h8, 1, 2'b00, 32'h5A5A_0F0F,
                  1, 2'b01, 2'b00, 32'h5A5A_0F0F};

      valid         = '0;
      address       = '0;
      write         = '0;
      write_data    = '0;
      strobe        = '0;
      bus_ready     = 1'b0;
      bus_status    = 2'b11;
      bus_read_data = 32'hFFFF_FFFF;
      #2 rst_n = 1'b0;
      step();
      step();
      chk("rst bus_valid", 32'(bus_valid), 32'd0);
      chk("rst ready", 32'(ready), 32'd0);
      chk("rst status", 32'(status), 32'd0);
      chk("rst rdata", read_data, 32'd0);
      chk("rst bus_addr", 32'(bus_address), 32'd0);
      chk("rst bus_wdata", bus_write_data, 32'd0);
      chk("rst bus_strobe_write", {27'd0, bus_write, bus_strobe}, 32'd0);
      rst_n = 1'b1;

      // Contention from reset: grants alternate starting at host 0, 3 cycles apart.
      exp_seq[0] = 2'b01;
      exp_seq[1] = 2'b10;
      exp_seq[2] = 2'b01;
      exp_seq[3] = 2'b10;
      valid         = 2'b11;
      address[0]    = 8'h01;
      address[1]    = 8'h02;
      bus_ready     = 1'b1;
      bus_status    = 2'b00;
      bus_read_data = 32'h0000_0C0C;
      prev = '0;
      n    = 0;
      last = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         step();
         if (ready != 2'b00) begin
            chk($sformatf("rr grant%0d", n), 32'(ready), 32'(exp_seq[n]));
            chk($sformatf("rr pulse%0d", n), 32'(prev), 32'd0);
            chk($sformatf("rr status%0d", n), 32'(status), 32'd0);
            if (n > 0) chk($sformatf("rr spacing%0d", n), 32'(cyc - last), 32'd3);
            last = cyc;
            n++;
         end
         prev = ready;
         if (n == 4) begin
            valid     = 2'b00;
            bus_ready = 1'b0;
            break;
         end
      end
      chk("rr count", 32'(n), 32'd4);
      bus_status    = 2'b11;
      bus_read_data = 32'hFFFF_FFFF;
      step();
      chk("rr idle ready", 32'(ready), 32'd0);

      for (int i = 0; i < 5; i++) begin
         run_vec($sformatf("v%0d", i), vecs[i]);
      end

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
      tv = '{1, 1'b0, 8'h66, 32'h0, 4'h0, 0, 2'b00, 32'h0,
             4, 2'b10, 2'b10, 32'h0000_0000};
      run_vec("tmo", tv);
      tv = '{0, 1'b0, 8'h67, 32'h0, 4'h0, 4, 2'b01, 32'hCAFE_F00D,
             4, 2'b01, 2'b01, 32'hCAFE_F00D};
      run_vec("tmo_prio", tv);
`else
      tv = '{1, 1'b0, 8'h66, 32'h0, 4'h0, 7, 2'b01, 32'h7777_0000,
             7, 2'b10, 2'b01, 32'h7777_0000};
      run_vec("no_tmo", tv);
      tv = '{0, 1'b1, 8'h67, 32'h3, 4'h1, 1, 2'b00, 32'h0,
             1, 2'b01, 2'b00, 32'h0};
      run_vec("no_tmo2", tv);
`endif

      // Pointer now favours host 1; a reset mid-access must return it to host 0.
      valid      = 2'b11;
      address[0] = 8'h31;
      address[1] = 8'h32;
      write      = 2'b00;
      step();
      chk("mrst grant1 valid", 32'(bus_valid), 32'd1);
      chk("mrst grant1 addr", 32'(bus_address), 32'h32);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst async valid", 32'(bus_valid), 32'd0);
      chk("mrst async ready", 32'(ready), 32'd0);
      step();
      chk("mrst held ready", 32'(ready), 32'd0);
      chk("mrst held addr", 32'(bus_address), 32'd0);
      rst_n = 1'b1;
      step();
      chk("mrst regrant valid", 32'(bus_valid), 32'd1);
      chk("mrst regrant addr", 32'(bus_address), 32'h31);
      bus_ready     = 1'b1;
      bus_status    = 2'b00;
      bus_read_data = 32'h0BAD_CAFE;
      step();
      bus_ready = 1'b0;
      chk("mrst ready", 32'(ready), 32'b01);
      chk("mrst rdata", read_data, 32'h0BAD_CAFE);
      valid = 2'b00;
      step();
      chk("mrst idle", 32'(ready), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
